// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;

    typedef enum logic [1:0] {
        HUNT,
        CAPTURE,
        HOLD
    } state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/i2s_rx_sync.sv
// Brings BCK/WS/DIN into the clk32 domain and flags BCK rising edges.
module i2s_rx_sync
    import i2s_pkg::*;
(
    input  logic clk32,
    input  logic por,
    input  logic i2s_bck,
    input  logic i2s_ws,
    input  logic i2s_din,
    output logic bck_rise,
    output logic ws_s,
    output logic din_s
);

    // bck carries one extra stage so its edge lines up with ws/din stage outputs
    logic [SYNC_STAGES:0]   bck_sync;
    logic [SYNC_STAGES-1:0] ws_sync;
    logic [SYNC_STAGES-1:0] din_sync;

    always_ff @(posedge clk32) begin
        if (por) begin
            bck_sync <= '0;
            ws_sync  <= '0;
            din_sync <= '0;
        end else begin
            bck_sync <= {bck_sync[SYNC_STAGES-1:0], i2s_bck};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], i2s_ws};
            din_sync <= {din_sync[SYNC_STAGES-2:0], i2s_din};
        end
    end

    assign bck_rise = bck_sync[SYNC_STAGES-1] & ~bck_sync[SYNC_STAGES];
    assign ws_s     = ws_sync[SYNC_STAGES-1];
    assign din_s    = din_sync[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// Philips-format I2S receiver: frames stereo words from oversampled BCK/WS/DIN.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clk32,
    input  logic                  por,
    input  logic                  i2s_bck,
    input  logic                  i2s_ws,
    input  logic                  i2s_din,
    output logic [DATA_WIDTH-1:0] audio_l,
    output logic [DATA_WIDTH-1:0] audio_r,
    output logic                  audio_valid,
    output logic                  locked,
    output logic                  err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    logic bck_rise, ws_s, din_s, ws_edge;

    i2s_rx_sync u_sync (
        .clk32   (clk32),
        .por     (por),
        .i2s_bck (i2s_bck),
        .i2s_ws  (i2s_ws),
        .i2s_din (i2s_din),
        .bck_rise(bck_rise),
        .ws_s    (ws_s),
        .din_s   (din_s)
    );

    state_t                        state, state_nxt;
    logic [CNT_W-1:0]              cnt, cnt_nxt;
    logic [TO_W-1:0]               to_cnt, to_nxt;
    logic                          ch, ch_nxt;
    logic                          ws_prev, ws_prev_nxt;
    logic                          left_ok, left_ok_nxt;
    logic signed [DATA_WIDTH-1:0]  shift, shift_nxt;
    logic signed [DATA_WIDTH-1:0]  left_hold, left_nxt;
    logic [DATA_WIDTH-1:0]         l_nxt, r_nxt;
    logic                          valid_nxt, locked_nxt, err_nxt;

    assign ws_edge = ws_s != ws_prev;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        to_nxt      = to_cnt;
        ch_nxt      = ch;
        ws_prev_nxt = ws_prev;
        left_ok_nxt = left_ok;
        shift_nxt   = shift;
        left_nxt    = left_hold;
        l_nxt       = audio_l;
        r_nxt       = audio_r;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;
        locked_nxt  = locked;
        if (bck_rise) begin
            to_nxt      = '0;
            ws_prev_nxt = ws_s;
            unique case (state)
                HUNT: begin
                    if (ws_edge && !ws_s) begin
                        cnt_nxt     = '0;
                        ch_nxt      = 1'b0;
                        left_ok_nxt = 1'b0;
                        state_nxt   = CAPTURE;
                    end
                end
                CAPTURE: begin
                    // any WS change here means the slot ended before a full word
                    if (ws_edge) begin
                        err_nxt     = 1'b1;
                        locked_nxt  = 1'b0;
                        left_ok_nxt = 1'b0;
                        cnt_nxt     = '0;
                        shift_nxt   = '0;
                        state_nxt   = HUNT;
                    end else begin
                        shift_nxt = {shift[DATA_WIDTH-2:0], din_s};
                        cnt_nxt   = cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state_nxt = HOLD;
                            if (!ch) begin
                                left_nxt    = shift_nxt;
                                left_ok_nxt = 1'b1;
                            end else if (left_ok) begin
                                l_nxt       = left_hold;
                                r_nxt       = shift_nxt;
                                valid_nxt   = 1'b1;
                                locked_nxt  = 1'b1;
                                left_ok_nxt = 1'b0;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (ws_edge) begin
                        cnt_nxt   = '0;
                        ch_nxt    = ws_s;
                        state_nxt = CAPTURE;
                        if (!ws_s) left_ok_nxt = 1'b0;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end else begin
            if (to_cnt != TO_MAX) to_nxt = to_cnt + 1'b1;
            if (to_cnt == TO_LAST) begin
                locked_nxt  = 1'b0;
                left_ok_nxt = 1'b0;
                state_nxt   = HUNT;
            end
        end
    end

    always_ff @(posedge clk32) begin
        if (por) begin
            state       <= HUNT;
            cnt         <= '0;
            to_cnt      <= '0;
            ch          <= 1'b0;
            ws_prev     <= 1'b0;
            left_ok     <= 1'b0;
            shift       <= '0;
            left_hold   <= '0;
            audio_l     <= '0;
            audio_r     <= '0;
            audio_valid <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            to_cnt      <= to_nxt;
            ch          <= ch_nxt;
            ws_prev     <= ws_prev_nxt;
            left_ok     <= left_ok_nxt;
            shift       <= shift_nxt;
            left_hold   <= left_nxt;
            audio_l     <= l_nxt;
            audio_r     <= r_nxt;
            audio_valid <= valid_nxt;
            locked      <= locked_nxt;
            err         <= err_nxt;
        end
    end

endmodule
